// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter in front of the register file write port.
// Define WB_FORWARD_EN to bypass the in-flight write onto the read ports.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [AW-1:0]   req0_rd,
    input  logic [XLEN-1:0] req0_data,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [AW-1:0]   req1_rd,
    input  logic [XLEN-1:0] req1_data,
    output logic            rf_reg_write,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_write_data,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [XLEN-1:0] rf_read_data1,
    input  logic [XLEN-1:0] rf_read_data2,
    output logic [XLEN-1:0] fwd_read_data1,
    output logic [XLEN-1:0] fwd_read_data2,
    output logic            busy
);

    typedef struct packed {
        logic            full;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } slot_t;

    slot_t slot0;
    slot_t slot1;
    logic  last_grant;
    logic  grant0;
    logic  grant1;
    logic  take0;
    logic  take1;

    // On contention the slot that did not win last time goes first.
    assign grant0 = slot0.full & (~slot1.full | last_grant);
    assign grant1 = slot1.full & (~slot0.full | ~last_grant);

    assign req0_ready = ~slot0.full | grant0;
    assign req1_ready = ~slot1.full | grant1;

    assign take0 = req0_valid & req0_ready;
    assign take1 = req1_valid & req1_ready;

    assign busy = slot0.full | slot1.full | rf_reg_write;

    // A transfer to x0 is accepted but leaves the slot empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
        end else if (take0) begin
            slot0.full <= |req0_rd;
            slot0.rd   <= req0_rd;
            slot0.data <= req0_data;
        end else if (grant0) begin
            slot0.full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot1 <= '0;
        end else if (take1) begin
            slot1.full <= |req1_rd;
            slot1.rd   <= req1_rd;
            slot1.data <= req1_data;
        end else if (grant1) begin
            slot1.full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_reg_write  <= 1'b0;
            rf_rd         <= '0;
            rf_write_data <= '0;
            last_grant    <= 1'b1;
        end else if (grant0) begin
            rf_reg_write  <= 1'b1;
            rf_rd         <= slot0.rd;
            rf_write_data <= slot0.data;
            last_grant    <= 1'b0;
        end else if (grant1) begin
            rf_reg_write  <= 1'b1;
            rf_rd         <= slot1.rd;
            rf_write_data <= slot1.data;
            last_grant    <= 1'b1;
        end else begin
            rf_reg_write  <= 1'b0;
        end
    end

`ifdef WB_FORWARD_EN
    logic hit1;
    logic hit2;

    assign hit1 = rf_reg_write & (rs1 == rf_rd) & (|rs1);
    assign hit2 = rf_reg_write & (rs2 == rf_rd) & (|rs2);

    assign fwd_read_data1 = hit1 ? rf_write_data : rf_read_data1;
    assign fwd_read_data2 = hit2 ? rf_write_data : rf_read_data2;
`else
    logic unused_rs;

    assign unused_rs      = ^{rs1, rs2};
    assign fwd_read_data1 = rf_read_data1;
    assign fwd_read_data2 = rf_read_data2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// checked against a slot/round-robin reference model and a regfile array.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_rd, req1_rd;
    logic [31:0] req0_data, req1_data;
    logic        rf_reg_write;
    logic [4:0]  rf_rd;
    logic [31:0] rf_write_data;
    logic [4:0]  rs1, rs2;
    logic [31:0] rf_read_data1, rf_read_data2;
    logic [31:0] fwd_read_data1, fwd_read_data2;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rd(req0_rd), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rd(req1_rd), .req1_data(req1_data),
        .rf_reg_write(rf_reg_write), .rf_rd(rf_rd),
        .rf_write_data(rf_write_data),
        .rs1(rs1), .rs2(rs2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .fwd_read_data1(fwd_read_data1), .fwd_read_data2(fwd_read_data2),
        .busy(busy)
    );

    // Register file attached to the write port
    logic [31:0] tb_mem [32];
    always @(posedge clk)
        if (rf_reg_write && rf_rd != 5'd0) tb_mem[rf_rd] <= rf_write_data;
    assign rf_read_data1 = tb_mem[rs1];
    assign rf_read_data2 = tb_mem[rs2];

    // Reference model
    bit          m_full [2];
    logic [4:0]  m_rd   [2];
    logic [31:0] m_data [2];
    int          m_last;
    bit          m_wr;
    logic [4:0]  m_wrd;
    logic [31:0] m_wdata;
    logic [31:0] m_mem  [32];

    function automatic int m_grant();
        if (m_full[0] && m_full[1]) return 1 - m_last;
        if (m_full[0]) return 0;
        if (m_full[1]) return 1;
        return -1;
    endfunction

    function automatic bit m_ready(int i);
        return !m_full[i] || m_grant() == i;
    endfunction

    function automatic bit m_busy();
        return m_full[0] || m_full[1] || m_wr;
    endfunction

    function automatic logic [31:0] m_fwd(logic [4:0] rs);
`ifdef WB_FORWARD_EN
        if (m_wr && rs == m_wrd && rs != 5'd0) return m_wdata;
`endif
        return m_mem[rs];
    endfunction

    task automatic m_reset();
        m_full[0] = 0; m_full[1] = 0;
        m_last = 1; m_wr = 0; m_wrd = '0; m_wdata = '0;
    endtask

    task automatic m_step();
        bit v[2]; bit rdy[2];
        logic [4:0] r[2]; logic [31:0] d[2];
        int g;
        if (!rst_n) return;
        v[0] = req0_valid; r[0] = req0_rd; d[0] = req0_data;
        v[1] = req1_valid; r[1] = req1_rd; d[1] = req1_data;
        g = m_grant();
        rdy[0] = m_ready(0);
        rdy[1] = m_ready(1);
        if (m_wr && m_wrd != 5'd0) m_mem[m_wrd] = m_wdata;
        if (g >= 0) begin
            m_wr = 1; m_wrd = m_rd[g]; m_wdata = m_data[g];
            m_last = g; m_full[g] = 0;
        end else begin
            m_wr = 0;
        end
        for (int i = 0; i < 2; i++)
            if (v[i] && rdy[i] && r[i] != 5'd0) begin
                m_full[i] = 1; m_rd[i] = r[i]; m_data[i] = d[i];
            end
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic drive(input bit v0, input logic [4:0] r0,
                         input logic [31:0] d0, input bit v1,
                         input logic [4:0] r1, input logic [31:0] d1);
        req0_valid = v0; req0_rd = r0; req0_data = d0;
        req1_valid = v1; req1_rd = r1; req1_data = d1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rs1 = '0; rs2 = '0;
        drive(1, 5'd1, 32'h1111, 1, 5'd2, 32'h2222);
        m_reset();
        repeat (2) tick();
        checks++;
        if (rf_reg_write !== 1'b0) begin
            errors++; $display("FAIL reset_we got=%b exp=0", rf_reg_write);
        end
        checks++;
        if (rf_rd !== 5'd0) begin
            errors++; $display("FAIL reset_rd got=%0d exp=0", rf_rd);
        end
        checks++;
        if (rf_write_data !== 32'd0) begin
            errors++; $display("FAIL reset_data got=%h exp=0", rf_write_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got=%b exp=0", busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (rf_reg_write !== 1'b0) begin
            errors++; $display("FAIL release_edge1 got=%b exp=0", rf_reg_write);
        end
        tick();
        checks++;
        if (rf_reg_write !== 1'b1 || rf_rd !== 5'd1) begin
            errors++;
            $display("FAIL release_edge2 we=%b rd=%0d exp we=1 rd=1",
                     rf_reg_write, rf_rd);
        end
        drive(0, '0, '0, 0, '0, '0);
        repeat (4) tick();
    endtask

    task automatic test_single_write();
        drive(1, 5'd3, 32'hABCD1234, 0, '0, '0);
        tick();
        drive(0, '0, '0, 0, '0, '0);
        #1;
        checks++;
        if (rf_reg_write !== 1'b0) begin
            errors++; $display("FAIL single_early got=%b exp=0", rf_reg_write);
        end
        tick();
        checks++;
        if (rf_reg_write !== 1'b1 || rf_rd !== 5'd3
            || rf_write_data !== 32'hABCD1234) begin
            errors++;
            $display("FAIL single_write we=%b rd=%0d data=%h exp 1/3/abcd1234",
                     rf_reg_write, rf_rd, rf_write_data);
        end
        tick();
        checks++;
        if (rf_reg_write !== 1'b0) begin
            errors++; $display("FAIL single_once got=%b exp=0", rf_reg_write);
        end
        rs1 = 5'd3;
        #1;
        checks++;
        if (fwd_read_data1 !== 32'hABCD1234) begin
            errors++;
            $display("FAIL single_read got=%h exp=abcd1234", fwd_read_data1);
        end
    endtask

    task automatic test_contention();
        logic [4:0] exp_rd;
        do_reset();
        drive(1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222);
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL cont_ready k=%0d got=%b%b exp=%b%b", k,
                         req0_ready, req1_ready, k % 2 == 0, k % 2 == 1);
            end
            tick();
            exp_rd = (k % 2 == 0) ? 5'd1 : 5'd2;
            checks++;
            if (rf_reg_write !== 1'b1 || rf_rd !== exp_rd) begin
                errors++;
                $display("FAIL cont_rd k=%0d we=%b rd=%0d exp rd=%0d",
                         k, rf_reg_write, rf_rd, exp_rd);
            end
        end
        drive(0, '0, '0, 0, '0, '0);
        repeat (4) tick();
    endtask

    task automatic test_x0_discard();
        drive(0, '0, '0, 1, 5'd0, 32'hDEADBEEF);
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("FAIL x0_ready got=%b exp=1", req1_ready);
        end
        tick();
        drive(0, '0, '0, 0, '0, '0);
        #1;
        checks++;
        if (rf_reg_write !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL x0_edge1 we=%b busy=%b exp 0/0", rf_reg_write, busy);
        end
        tick();
        checks++;
        if (rf_reg_write !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL x0_edge2 we=%b busy=%b exp 0/0", rf_reg_write, busy);
        end
    endtask

    task automatic test_same_addr();
        do_reset();
        drive(1, 5'd5, 32'hAAAA0000, 1, 5'd5, 32'hBBBB0000);
        tick();
        drive(0, '0, '0, 0, '0, '0);
        tick();
        checks++;
        if (rf_rd !== 5'd5 || rf_write_data !== 32'hAAAA0000) begin
            errors++;
            $display("FAIL same_first rd=%0d data=%h exp 5/aaaa0000",
                     rf_rd, rf_write_data);
        end
        tick();
        checks++;
        if (rf_rd !== 5'd5 || rf_write_data !== 32'hBBBB0000) begin
            errors++;
            $display("FAIL same_second rd=%0d data=%h exp 5/bbbb0000",
                     rf_rd, rf_write_data);
        end
        tick();
        rs1 = 5'd5;
        #1;
        checks++;
        if (fwd_read_data1 !== 32'hBBBB0000) begin
            errors++;
            $display("FAIL same_read got=%h exp=bbbb0000", fwd_read_data1);
        end
    endtask

    task automatic test_forward();
        logic [31:0] exp1;
        drive(1, 5'd7, 32'h12345678, 0, '0, '0);
        tick();
        drive(0, '0, '0, 0, '0, '0);
        tick();
        rs1 = 5'd7;
        rs2 = 5'd0;
        #1;
`ifdef WB_FORWARD_EN
        exp1 = 32'h12345678;
`else
        exp1 = m_mem[7];
`endif
        checks++;
        if (rf_reg_write !== 1'b1 || rf_rd !== 5'd7) begin
            errors++;
            $display("FAIL fwd_setup we=%b rd=%0d exp 1/7", rf_reg_write, rf_rd);
        end
        checks++;
        if (fwd_read_data1 !== exp1) begin
            errors++; $display("FAIL fwd_rs1 got=%h exp=%h", fwd_read_data1, exp1);
        end
        checks++;
        if (fwd_read_data2 !== m_mem[0]) begin
            errors++;
            $display("FAIL fwd_rs2 got=%h exp=%h", fwd_read_data2, m_mem[0]);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)),
                  $urandom,
                  $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)),
                  $urandom);
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            #1;
            checks++;
            if (req0_ready !== m_ready(0) || req1_ready !== m_ready(1)) begin
                errors++;
                $display("FAIL rnd_ready n=%0d got=%b%b exp=%b%b", n,
                         req0_ready, req1_ready, m_ready(0), m_ready(1));
            end
            checks++;
            if (busy !== m_busy()) begin
                errors++;
                $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy, m_busy());
            end
            checks++;
            if (fwd_read_data1 !== m_fwd(rs1) || fwd_read_data2 !== m_fwd(rs2)) begin
                errors++;
                $display("FAIL rnd_fwd n=%0d got=%h/%h exp=%h/%h", n,
                         fwd_read_data1, fwd_read_data2, m_fwd(rs1), m_fwd(rs2));
            end
            tick();
            checks++;
            if (rf_reg_write !== m_wr || rf_rd !== m_wrd
                || rf_write_data !== m_wdata) begin
                errors++;
                $display("FAIL rnd_out n=%0d got=%b/%0d/%h exp=%b/%0d/%h", n,
                         rf_reg_write, rf_rd, rf_write_data, m_wr, m_wrd, m_wdata);
            end
            if (n == 200) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (busy !== 1'b0 || rf_reg_write !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_async_reset busy=%b we=%b exp 0/0",
                             busy, rf_reg_write);
                end
                m_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        drive(0, '0, '0, 0, '0, '0);
        repeat (4) tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            tb_mem[i] = '0;
            m_mem[i]  = '0;
        end
        test_reset();
        test_single_write();
        test_contention();
        test_x0_discard();
        test_same_addr();
        test_forward();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
